alu_writeback: RTL and testbench

Result-side counterpart of the ALU operand muxes. Takes each completed ALU result (value, destination register, carry/overflow) and retires it through the single register-file write port, where memory-load data has priority. Pending ALU results wait in a 2-entry queue. The block keeps the architectural Z/N/C/V flags and forwards not-yet-written values to the operand read path.

---
 rtl/alu_writeback.sv | 165 ++++++++++++++++
 tb/tb_alu_writeback.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback
//  Description : Retires ALU results through the single register-file write
//                port. Memory-load writebacks have priority, and waiting ALU
//                results sit in a 2-entry in-order queue. Holds the
//                architectural Z/N/C/V flags and forwards values that are not
//                yet written to the operand read path.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_writeback #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ALU_VALID,
    input  logic [WIDTH-1:0]  ALU_RESULT,
    input  logic [ADDR_W-1:0] ALU_DEST,
    input  logic              ALU_WB_EN,
    input  logic              ALU_C,
    input  logic              ALU_V,
    input  logic              FLAGS_EN,
    input  logic              LOAD_VALID,
    input  logic [WIDTH-1:0]  LOAD_DATA,
    input  logic [ADDR_W-1:0] LOAD_DEST,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic              RF_WE,
    output logic [ADDR_W-1:0] RF_WADDR,
    output logic [WIDTH-1:0]  RF_WDATA,
    output logic [3:0]        FLAGS,
    output logic              STALL,
    output logic [1:0]        PENDING,
    output logic              FWD_HIT,
    output logic [WIDTH-1:0]  FWD_DATA
);

    localparam logic [1:0] c_FULL = 2'd2;

    // Queue storage, wrap-around pointers and occupancy
    logic [WIDTH-1:0]  r_q_data [0:1];
    logic [ADDR_W-1:0] r_q_addr [0:1];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_count;

    // Write-port stage and flags
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [WIDTH-1:0]  r_rf_wdata;
    logic [3:0]        r_flags;

    // Arbitration results
    logic              w_stall;
    logic              w_accept;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_newest;

    assign w_stall    = (r_count == c_FULL);
    assign w_accept   = ALU_VALID & ~w_stall;
    assign w_push_req = w_accept & ALU_WB_EN;
    // With one entry the newest is the head; with two it is the slot behind the tail.
    assign w_newest   = ~r_tail;

    // Pick this cycle's register-file write: load, then queue head, then bypass.
    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_addr = r_rf_waddr;
        w_sel_data = r_rf_wdata;
        w_pop      = 1'b0;
        w_push     = 1'b0;
        if (LOAD_VALID) begin
            w_sel_we   = 1'b1;
            w_sel_addr = LOAD_DEST;
            w_sel_data = LOAD_DATA;
            w_push     = w_push_req;
        end else if (r_count != 2'd0) begin
            w_sel_we   = 1'b1;
            w_sel_addr = r_q_addr[r_head];
            w_sel_data = r_q_data[r_head];
            w_pop      = 1'b1;
            w_push     = w_push_req;
        end else if (w_push_req) begin
            w_sel_we   = 1'b1;
            w_sel_addr = ALU_DEST;
            w_sel_data = ALU_RESULT;
        end
    end

    // Queue pointer/occupancy update; stored entries need no reset since
    // nothing reads a slot beyond the current occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_q_data[r_tail] <= ALU_RESULT;
                r_q_addr[r_tail] <= ALU_DEST;
                r_tail           <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Register the selected write; address/data hold when nothing is written.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we    <= w_sel_we;
            r_rf_waddr <= w_sel_addr;
            r_rf_wdata <= w_sel_data;
        end
    end

    // Architectural flags follow every accepted flag-setting result, written or not.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_flags <= 4'b0000;
        end else if (w_accept && FLAGS_EN) begin
            r_flags <= {(ALU_RESULT == '0), ALU_RESULT[WIDTH-1], ALU_C, ALU_V};
        end
    end

    // Forward the newest unwritten value for RD_ADDR; the incoming ALU result is excluded.
    always_comb begin
        FWD_HIT  = 1'b0;
        FWD_DATA = '0;
        if ((r_count != 2'd0) && (r_q_addr[w_newest] == RD_ADDR)) begin
            FWD_HIT  = 1'b1;
            FWD_DATA = r_q_data[w_newest];
        end else if ((r_count == c_FULL) && (r_q_addr[r_head] == RD_ADDR)) begin
            FWD_HIT  = 1'b1;
            FWD_DATA = r_q_data[r_head];
        end else if (r_rf_we && (r_rf_waddr == RD_ADDR)) begin
            FWD_HIT  = 1'b1;
            FWD_DATA = r_rf_wdata;
        end
    end

    assign RF_WE    = r_rf_we;
    assign RF_WADDR = r_rf_waddr;
    assign RF_WDATA = r_rf_wdata;
    assign FLAGS    = r_flags;
    assign STALL    = w_stall;
    assign PENDING  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_writeback
//  Description : Self-checking bench for alu_writeback: directed scenarios
//                followed by randomized traffic against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_writeback;

    logic        CLK;
    logic        RESET;
    logic        ALU_VALID;
    logic [15:0] ALU_RESULT;
    logic [3:0]  ALU_DEST;
    logic        ALU_WB_EN;
    logic        ALU_C;
    logic        ALU_V;
    logic        FLAGS_EN;
    logic        LOAD_VALID;
    logic [15:0] LOAD_DATA;
    logic [3:0]  LOAD_DEST;
    logic [3:0]  RD_ADDR;
    logic        RF_WE;
    logic [3:0]  RF_WADDR;
    logic [15:0] RF_WDATA;
    logic [3:0]  FLAGS;
    logic        STALL;
    logic [1:0]  PENDING;
    logic        FWD_HIT;
    logic [15:0] FWD_DATA;

    alu_writeback #(.WIDTH(16), .ADDR_W(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ALU_VALID  (ALU_VALID),
        .ALU_RESULT (ALU_RESULT),
        .ALU_DEST   (ALU_DEST),
        .ALU_WB_EN  (ALU_WB_EN),
        .ALU_C      (ALU_C),
        .ALU_V      (ALU_V),
        .FLAGS_EN   (FLAGS_EN),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_DEST  (LOAD_DEST),
        .RD_ADDR    (RD_ADDR),
        .RF_WE      (RF_WE),
        .RF_WADDR   (RF_WADDR),
        .RF_WDATA   (RF_WDATA),
        .FLAGS      (FLAGS),
        .STALL      (STALL),
        .PENDING    (PENDING),
        .FWD_HIT    (FWD_HIT),
        .FWD_DATA   (FWD_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending results as a plain FIFO, plus the write stage and flags
    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic        m_we;
    logic [3:0]  m_waddr;
    logic [15:0] m_wdata;
    logic [3:0]  m_flags;

    task automatic model_reset();
        m_q.delete();
        m_we    = 1'b0;
        m_waddr = 4'd0;
        m_wdata = 16'd0;
        m_flags = 4'd0;
    endtask

    task automatic model_edge();
        bit   acc;
        ent_t e;
        if (RESET) begin
            model_reset();
            return;
        end
        acc = ALU_VALID && (m_q.size() < 2);
        if (acc && FLAGS_EN)
            m_flags = {ALU_RESULT == 16'd0, ALU_RESULT[15], ALU_C, ALU_V};
        e.a = ALU_DEST;
        e.d = ALU_RESULT;
        if (LOAD_VALID) begin
            m_we = 1'b1; m_waddr = LOAD_DEST; m_wdata = LOAD_DATA;
            if (acc && ALU_WB_EN) m_q.push_back(e);
        end else if (m_q.size() > 0) begin
            ent_t h = m_q.pop_front();
            m_we = 1'b1; m_waddr = h.a; m_wdata = h.d;
            if (acc && ALU_WB_EN) m_q.push_back(e);
        end else if (acc && ALU_WB_EN) begin
            m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic model_fwd(output logic hit, output logic [15:0] data);
        hit  = 1'b0;
        data = 16'd0;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (!hit && m_q[i].a == RD_ADDR) begin
                hit  = 1'b1;
                data = m_q[i].d;
            end
        end
        if (!hit && m_we && m_waddr == RD_ADDR) begin
            hit  = 1'b1;
            data = m_wdata;
        end
    endtask

    // One clock: check combinational outputs, clock it, check registered outputs.
    task automatic step();
        logic        eh;
        logic [15:0] ed;
        #1;
        model_fwd(eh, ed);
        chk("fwd_hit",  32'(FWD_HIT),  32'(eh));
        chk("fwd_data", 32'(FWD_DATA), 32'(ed));
        chk("stall_pre", 32'(STALL), 32'(m_q.size() == 2));
        @(posedge CLK);
        model_edge();
        #1;
        chk("rf_we",    32'(RF_WE),    32'(m_we));
        chk("rf_waddr", 32'(RF_WADDR), 32'(m_waddr));
        chk("rf_wdata", 32'(RF_WDATA), 32'(m_wdata));
        chk("flags",    32'(FLAGS),    32'(m_flags));
        chk("pending",  32'(PENDING),  32'(m_q.size()));
        chk("stall",    32'(STALL),    32'(m_q.size() == 2));
    endtask

    task automatic idle();
        RESET = 1'b0; ALU_VALID = 1'b0; ALU_RESULT = 16'd0; ALU_DEST = 4'd0;
        ALU_WB_EN = 1'b0; ALU_C = 1'b0; ALU_V = 1'b0; FLAGS_EN = 1'b0;
        LOAD_VALID = 1'b0; LOAD_DATA = 16'd0; LOAD_DEST = 4'd0; RD_ADDR = 4'd0;
    endtask

    task automatic alu(input logic [15:0] res, input logic [3:0] dst, input logic wb,
                       input logic fen, input logic c, input logic v);
        ALU_VALID = 1'b1; ALU_RESULT = res; ALU_DEST = dst; ALU_WB_EN = wb;
        FLAGS_EN = fen; ALU_C = c; ALU_V = v;
    endtask

    task automatic load(input logic [15:0] data, input logic [3:0] dst);
        LOAD_VALID = 1'b1; LOAD_DATA = data; LOAD_DEST = dst;
    endtask

    initial begin
        idle();
        model_reset();
        @(posedge CLK); #1;

        // Reset then idle
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("rst_we",      32'(RF_WE),    32'd0);
        chk("rst_flags",   32'(FLAGS),    32'd0);
        chk("rst_pending", 32'(PENDING),  32'd0);
        chk("rst_stall",   32'(STALL),    32'd0);
        chk("rst_wdata",   32'(RF_WDATA), 32'd0);
        step();

        // Bypass write
        alu(16'h8000, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("byp_we",    32'(RF_WE),    32'd1);
        chk("byp_waddr", 32'(RF_WADDR), 32'd3);
        chk("byp_wdata", 32'(RF_WDATA), 32'h8000);
        chk("byp_flags", 32'(FLAGS),    32'b0110);
        idle(); step();

        // Load priority fills the queue; a stalled result is ignored
        load(16'h1234, 4'd9);
        alu(16'h0001, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        alu(16'h0002, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("fill_pending", 32'(PENDING), 32'd2);
        chk("fill_stall",   32'(STALL),   32'd1);
        alu(16'h0000, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("stall_flags",   32'(FLAGS),    32'b0010);
        chk("stall_pending", 32'(PENDING),  32'd2);
        chk("load_waddr",    32'(RF_WADDR), 32'd9);
        idle(); step();
        chk("drain1_waddr", 32'(RF_WADDR), 32'd1);
        chk("drain1_wdata", 32'(RF_WDATA), 32'h0001);
        step();
        chk("drain2_waddr", 32'(RF_WADDR), 32'd2);
        chk("drain2_wdata", 32'(RF_WDATA), 32'h0002);
        step(); step();
        chk("drained_we", 32'(RF_WE), 32'd0);

        // Forwarding picks the newest queued entry
        load(16'h7777, 4'd7);
        alu(16'h00AA, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        alu(16'h00BB, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        ALU_VALID = 1'b0;
        RD_ADDR = 4'd5; #1;
        chk("fwd5_hit",  32'(FWD_HIT),  32'd1);
        chk("fwd5_data", 32'(FWD_DATA), 32'h00BB);
        RD_ADDR = 4'd6; #1;
        chk("fwd6_hit",  32'(FWD_HIT),  32'd0);
        chk("fwd6_data", 32'(FWD_DATA), 32'd0);
        RD_ADDR = 4'd7; #1;
        chk("fwd7_hit",  32'(FWD_HIT),  32'd1);
        chk("fwd7_data", 32'(FWD_DATA), 32'h7777);
        idle(); step(); step(); step(); step();

        // Flags-only compare
        alu(16'h0000, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("cmp_we",      32'(RF_WE),    32'd0);
        chk("cmp_pending", 32'(PENDING),  32'd0);
        chk("cmp_z",       32'(FLAGS[3]), 32'd1);
        idle(); step();

        // Reset mid-operation discards queued results
        load(16'h4444, 4'd4);
        alu(16'h0C0C, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        alu(16'h0D0D, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("pre_rst_pending", 32'(PENDING), 32'd2);
        RESET = 1'b1;
        step();
        idle();
        chk("mid_rst_pending", 32'(PENDING), 32'd0);
        chk("mid_rst_we",      32'(RF_WE),   32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_we", 32'(RF_WE), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RESET      = ($urandom_range(99) == 0);
            LOAD_VALID = ($urandom_range(99) < 35);
            LOAD_DATA  = 16'($urandom);
            LOAD_DEST  = 4'($urandom_range(3));
            ALU_VALID  = ($urandom_range(99) < 70);
            ALU_RESULT = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
            ALU_DEST   = 4'($urandom_range(3));
            ALU_WB_EN  = ($urandom_range(99) < 85);
            FLAGS_EN   = 1'($urandom);
            ALU_C      = 1'($urandom);
            ALU_V      = 1'($urandom);
            RD_ADDR    = 4'($urandom_range(4));
            step();
        end

        idle();
        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
